// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory-side end of the load/store-buffer issue interface.
//                Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and
//                sequences it as 1, 2 or 4 byte transfers, little-endian, on
//                the byte-wide memory arbiter port. Completion is signalled on
//                end_out. Load results are also broadcast on the CDB.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//    LSU_ROLLBACK_ABORT_EN  - when defined, roll_back_in aborts an in-flight
//                             load (no end_out, no CDB broadcast) and discards
//                             a load offered in the same cycle. Stores are
//                             never aborted. When undefined, roll_back_in is
//                             ignored.
// ----------------------------------------------------------------------------
//  Ports:
//    clk_in          in   1       clock
//    rst_in          in   1       asynchronous reset, active low
//    rdy_in          in   1       global ready; low freezes the unit
//    enable_in       in   1       request valid from the buffer
//    rw_flag_in      in   1       0 = read (load), 1 = write (store)
//    op_enum_in      in   OP_W    access type
//    addr_in         in   ADDR_W  byte address
//    data_in         in   DATA_W  store data
//    rob_id_in       in   ROB_W   ROB id of the request
//    roll_back_in    in   1       ROB flush
//    busy_out        out  1       cannot accept a request
//    end_out         out  1       one-cycle completion pulse
//    data_out        out  DATA_W  extended load data (valid with end_out)
//    cdb_valid_out   out  1       load result broadcast
//    cdb_rob_id_out  out  ROB_W   ROB id of the broadcast
//    cdb_result_out  out  DATA_W  broadcast value (equals data_out)
//    mem_req_out     out  1       byte request to the arbiter
//    mem_wr_out      out  1       1 = write
//    mem_a_out       out  ADDR_W  byte address
//    mem_dout_out    out  8       write byte
//    mem_gnt_in      in   1       arbiter accepted this cycle's byte
//    mem_din_in      in   8       read byte, valid the cycle after its grant
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int ROB_W  = 5,
    // Access-type encodings; override to match the core's op enumeration.
    parameter logic [OP_W-1:0] OP_LB  = OP_W'(0),
    parameter logic [OP_W-1:0] OP_LH  = OP_W'(1),
    parameter logic [OP_W-1:0] OP_LW  = OP_W'(2),
    parameter logic [OP_W-1:0] OP_LBU = OP_W'(3),
    parameter logic [OP_W-1:0] OP_LHU = OP_W'(4),
    parameter logic [OP_W-1:0] OP_SB  = OP_W'(5),
    parameter logic [OP_W-1:0] OP_SH  = OP_W'(6),
    parameter logic [OP_W-1:0] OP_SW  = OP_W'(7)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              enable_in,
    input  logic              rw_flag_in,
    input  logic [OP_W-1:0]   op_enum_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ROB_W-1:0]  rob_id_in,
    input  logic              roll_back_in,
    output logic              busy_out,
    output logic              end_out,
    output logic [DATA_W-1:0] data_out,
    output logic              cdb_valid_out,
    output logic [ROB_W-1:0]  cdb_rob_id_out,
    output logic [DATA_W-1:0] cdb_result_out,
    output logic              mem_req_out,
    output logic              mem_wr_out,
    output logic [ADDR_W-1:0] mem_a_out,
    output logic [7:0]        mem_dout_out,
    input  logic              mem_gnt_in,
    input  logic [7:0]        mem_din_in
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched request
    logic              r_store;
    logic              r_signed;
    logic [1:0]        r_last;      // index of the final byte (N-1)
    logic [1:0]        r_k;         // byte currently offered to the arbiter
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [ROB_W-1:0]  r_rob;

    // Load assembly: a granted read byte arrives one cycle later, so the
    // capture of byte k is remembered as pending until the next live edge.
    logic [DATA_W-1:0] r_asm;
    logic              r_cap_pend;
    logic [1:0]        r_cap_idx;

    // Result registers
    logic              r_end;
    logic              r_cdb;
    logic [DATA_W-1:0] r_dout;
    logic [ROB_W-1:0]  r_cdb_rob;

    logic              w_fire;
    logic              w_last_grant;
    logic              w_accept;
    logic              w_abort;
    logic [1:0]        w_dec_last;
    logic              w_dec_signed;
    logic [DATA_W-1:0] w_asm;
    logic [DATA_W-1:0] w_ext;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_last   = 2'd3;
        w_dec_signed = 1'b0;
        case (op_enum_in)
            OP_LB:  begin w_dec_last = 2'd0; w_dec_signed = 1'b1; end
            OP_LBU: w_dec_last = 2'd0;
            OP_SB:  w_dec_last = 2'd0;
            OP_LH:  begin w_dec_last = 2'd1; w_dec_signed = 1'b1; end
            OP_LHU: w_dec_last = 2'd1;
            OP_SH:  w_dec_last = 2'd1;
            OP_LW:  w_dec_last = 2'd3;
            OP_SW:  w_dec_last = 2'd3;
            default: w_dec_last = 2'd3;
        endcase
    end

    assign w_fire       = rdy_in & (r_state == S_XFER) & mem_gnt_in;
    assign w_last_grant = w_fire & (r_k == r_last);

`ifdef LSU_ROLLBACK_ABORT_EN
    // A flush is honoured even while frozen so a stale load cannot survive it.
    assign w_abort  = roll_back_in & ~r_store & (r_state != S_IDLE);
    assign w_accept = rdy_in & enable_in & (r_state == S_IDLE)
                    & ~(roll_back_in & ~rw_flag_in);
`else
    logic w_rollback_unused;
    assign w_rollback_unused = roll_back_in;
    assign w_abort  = 1'b0;
    assign w_accept = rdy_in & enable_in & (r_state == S_IDLE);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and bus request
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        mem_req_out = 1'b0;
        mem_wr_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                mem_req_out = rdy_in;
                mem_wr_out  = r_store;
                if (w_last_grant) w_state_nxt = r_store ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (rdy_in) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Final load value: merge the byte arriving this cycle, then extend
    // ------------------------------------------------------------------
    always_comb begin
        w_asm = r_asm;
        if (r_cap_pend) w_asm[{r_cap_idx, 3'b000} +: 8] = mem_din_in;
        case (r_last)
            2'd0:    w_ext = r_signed ? {{(DATA_W-8){w_asm[7]}},   w_asm[7:0]}
                                      : {{(DATA_W-8){1'b0}},       w_asm[7:0]};
            2'd1:    w_ext = r_signed ? {{(DATA_W-16){w_asm[15]}}, w_asm[15:0]}
                                      : {{(DATA_W-16){1'b0}},      w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_store    <= 1'b0;
            r_signed   <= 1'b0;
            r_last     <= 2'd0;
            r_k        <= 2'd0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rob      <= '0;
            r_asm      <= '0;
            r_cap_pend <= 1'b0;
            r_cap_idx  <= 2'd0;
            r_end      <= 1'b0;
            r_cdb      <= 1'b0;
            r_dout     <= '0;
            r_cdb_rob  <= '0;
        end else begin
            // Completion pulses last one cycle even while frozen.
            r_end <= 1'b0;
            r_cdb <= 1'b0;

            if (rdy_in) begin
                if (r_cap_pend) r_asm[{r_cap_idx, 3'b000} +: 8] <= mem_din_in;
                r_cap_pend <= w_fire & ~r_store;
                r_cap_idx  <= r_k;
                if (w_fire) r_k <= r_k + 2'd1;

                if (w_last_grant && r_store) r_end <= 1'b1;

                if (r_state == S_WAIT) begin
                    r_end     <= 1'b1;
                    r_cdb     <= 1'b1;
                    r_dout    <= w_ext;
                    r_cdb_rob <= r_rob;
                end
            end

            if (w_accept) begin
                r_store    <= rw_flag_in;
                r_signed   <= w_dec_signed;
                r_last     <= w_dec_last;
                r_k        <= 2'd0;
                r_addr     <= addr_in;
                r_data     <= data_in;
                r_rob      <= rob_id_in;
                r_asm      <= '0;
                r_cap_pend <= 1'b0;
            end

            if (w_abort) begin
                r_cap_pend <= 1'b0;
                r_end      <= 1'b0;
                r_cdb      <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_out       = (r_state != S_IDLE) | enable_in;
    assign end_out        = r_end;
    assign data_out       = r_dout;
    assign cdb_valid_out  = r_cdb;
    assign cdb_rob_id_out = r_cdb_rob;
    assign cdb_result_out = r_dout;
    assign mem_a_out      = r_addr + {{(ADDR_W-2){1'b0}}, r_k};
    assign mem_dout_out   = r_data[{r_k, 3'b000} +: 8];

endmodule
`default_nettype wire
